// File: rtl/mul_issue_arbiter.sv
// Round-robin issue of N_REQ requesters onto one pipelined multiplier, with a
// two-stage valid shadow for occupancy tracking and a drain/quiesce handshake.
module mul_issue_arbiter #(
    parameter int N_REQ  = 4,
    parameter int W_DATA = 16,
    parameter int W_P    = 5,
    parameter int W_TAG  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      freeze_back,
    input  logic                      drain_req,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*W_P-1:0]      req_Pw,
    input  logic [N_REQ*W_DATA-1:0]   req_busA,
    input  logic [N_REQ*W_DATA-1:0]   req_busB,
    input  logic [N_REQ*W_TAG-1:0]    req_tag_ROB,
    output logic [N_REQ-1:0]          req_grant,
    output logic                      valid_mul,
    output logic [W_P-1:0]            Pw_mul,
    output logic [W_DATA-1:0]         busA_mul,
    output logic [W_DATA-1:0]         busB_mul,
    output logic [W_TAG-1:0]          tag_ROB_mul,
    output logic [1:0]                inflight_cnt,
    output logic                      mul_busy,
    output logic                      drained
);

    localparam int PW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                valid_q, valid_d;
    logic [W_P-1:0]      pw_q, pw_d;
    logic [W_DATA-1:0]   bus_a_q, bus_a_d;
    logic [W_DATA-1:0]   bus_b_q, bus_b_d;
    logic [W_TAG-1:0]    tag_q, tag_d;
    logic                s1_q, s1_d;
    logic                s2_q, s2_d;
    logic [N_REQ-1:0]    grant;
    logic                grant_en;
    logic                found;
    logic [W_P-1:0]      sel_pw;
    logic [W_DATA-1:0]   sel_a;
    logic [W_DATA-1:0]   sel_b;
    logic [W_TAG-1:0]    sel_tag;

    // rst in the enable keeps req_grant low while reset is asserted
    assign grant_en = rst && (state_q == RUN) && !freeze_back && !flush;

    always_comb begin
        grant    = '0;
        found    = 1'b0;
        rr_ptr_d = rr_ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (grant_en && !found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                rr_ptr_d   = PW'((idx + 1) % N_REQ);
            end
        end
    end

    always_comb begin
        sel_pw  = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_tag = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_pw  = req_Pw[i*W_P +: W_P];
                sel_a   = req_busA[i*W_DATA +: W_DATA];
                sel_b   = req_busB[i*W_DATA +: W_DATA];
                sel_tag = req_tag_ROB[i*W_TAG +: W_TAG];
            end
        end
    end

    // Issue register and shadow stages: flush beats freeze, freeze holds all
    always_comb begin
        valid_d = valid_q;
        pw_d    = pw_q;
        bus_a_d = bus_a_q;
        bus_b_d = bus_b_q;
        tag_d   = tag_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        if (flush) begin
            valid_d = 1'b0;
            pw_d    = '0;
            bus_a_d = '0;
            bus_b_d = '0;
            tag_d   = '0;
            s1_d    = 1'b0;
            s2_d    = 1'b0;
        end else if (!freeze_back) begin
            valid_d = found;
            pw_d    = sel_pw;
            bus_a_d = sel_a;
            bus_b_d = sel_b;
            tag_d   = sel_tag;
            s1_d    = valid_q;
            s2_d    = s1_q;
        end
    end

    assign inflight_cnt = {1'b0, valid_q} + {1'b0, s1_q} + {1'b0, s2_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (drain_req) state_d = DRAIN;
            DRAIN: begin
                if (!drain_req)             state_d = RUN;
                else if (inflight_cnt == 0) state_d = DRAINED;
            end
            DRAINED: if (!drain_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            rr_ptr_q <= '0;
            valid_q  <= 1'b0;
            pw_q     <= '0;
            bus_a_q  <= '0;
            bus_b_q  <= '0;
            tag_q    <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
            pw_q     <= pw_d;
            bus_a_q  <= bus_a_d;
            bus_b_q  <= bus_b_d;
            tag_q    <= tag_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
        end
    end

    assign req_grant   = grant;
    assign valid_mul   = valid_q;
    assign Pw_mul      = pw_q;
    assign busA_mul    = bus_a_q;
    assign busB_mul    = bus_b_q;
    assign tag_ROB_mul = tag_q;
    assign mul_busy    = (inflight_cnt != 2'd0);
    assign drained     = (state_q == DRAINED);

endmodule

// File: tb/tb_mul_issue_arbiter.sv
// Directed bench for mul_issue_arbiter: hand-computed grants, payloads,
// occupancy and drain states, checked 1-2 ns after each rising edge.
module tb_mul_issue_arbiter;

    localparam int N_REQ  = 4;
    localparam int W_DATA = 16;
    localparam int W_P    = 5;
    localparam int W_TAG  = 5;

    logic                    clk;
    logic                    rst;
    logic                    flush;
    logic                    freeze_back;
    logic                    drain_req;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*W_P-1:0]    req_Pw;
    logic [N_REQ*W_DATA-1:0] req_busA;
    logic [N_REQ*W_DATA-1:0] req_busB;
    logic [N_REQ*W_TAG-1:0]  req_tag_ROB;
    logic [N_REQ-1:0]        req_grant;
    logic                    valid_mul;
    logic [W_P-1:0]          Pw_mul;
    logic [W_DATA-1:0]       busA_mul;
    logic [W_DATA-1:0]       busB_mul;
    logic [W_TAG-1:0]        tag_ROB_mul;
    logic [1:0]              inflight_cnt;
    logic                    mul_busy;
    logic                    drained;

    int n_cmp = 0;
    int n_err = 0;

    mul_issue_arbiter #(
        .N_REQ (N_REQ),
        .W_DATA(W_DATA),
        .W_P   (W_P),
        .W_TAG (W_TAG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .freeze_back (freeze_back),
        .drain_req   (drain_req),
        .req_valid   (req_valid),
        .req_Pw      (req_Pw),
        .req_busA    (req_busA),
        .req_busB    (req_busB),
        .req_tag_ROB (req_tag_ROB),
        .req_grant   (req_grant),
        .valid_mul   (valid_mul),
        .Pw_mul      (Pw_mul),
        .busA_mul    (busA_mul),
        .busB_mul    (busB_mul),
        .tag_ROB_mul (tag_ROB_mul),
        .inflight_cnt(inflight_cnt),
        .mul_busy    (mul_busy),
        .drained     (drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Requester i: A=0x0A0i, B=0x0B0i, Pw=i+1, tag=i+8
    task automatic load_default();
        for (int i = 0; i < N_REQ; i++) begin
            req_busA[i*W_DATA +: W_DATA]  = 16'h0A00 + 16'(i);
            req_busB[i*W_DATA +: W_DATA]  = 16'h0B00 + 16'(i);
            req_Pw[i*W_P +: W_P]          = 5'(i + 1);
            req_tag_ROB[i*W_TAG +: W_TAG] = 5'(i + 8);
        end
    endtask

    initial begin
        logic [3:0] rr_exp [4];
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000;

        rst = 1'b0; flush = 1'b0; freeze_back = 1'b0; drain_req = 1'b0;
        req_valid = 4'b1111;
        load_default();
        #2;
        check("rst_grant", 32'(req_grant), 32'h0);
        check("rst_valid", 32'(valid_mul), 32'h0);
        check("rst_pw", 32'(Pw_mul), 32'h0);
        check("rst_busA", 32'(busA_mul), 32'h0);
        check("rst_busB", 32'(busB_mul), 32'h0);
        check("rst_tag", 32'(tag_ROB_mul), 32'h0);
        check("rst_cnt", 32'(inflight_cnt), 32'h0);
        check("rst_busy", 32'(mul_busy), 32'h0);
        check("rst_drained", 32'(drained), 32'h0);

        @(posedge clk); #1;
        rst = 1'b1;
        // Round-robin with all four requesting
        for (int k = 0; k < 4; k++) begin
            if (k > 0) next_cycle();
            req_valid = 4'b1111;
            #1;
            check($sformatf("rr_grant%0d", k), 32'(req_grant), 32'(rr_exp[k]));
            check($sformatf("rr_cnt%0d", k), 32'(inflight_cnt), 32'(k));
            if (k > 0) check($sformatf("rr_busA%0d", k), 32'(busA_mul), 32'h0A00 + 32'(k - 1));
        end
        next_cycle(); req_valid = 4'b0100; #1;
        check("rr_busA3", 32'(busA_mul), 32'h0A03);
        check("rr_busB3", 32'(busB_mul), 32'h0B03);
        check("rr_pw3", 32'(Pw_mul), 32'd4);
        check("rr_tag3", 32'(tag_ROB_mul), 32'd11);
        check("rr_cnt_full", 32'(inflight_cnt), 32'd3);
        check("ptr_set3", 32'(req_grant), 32'b0100);

        // Wrap from rr_ptr=3 with 0101, then skip 1 and 3
        next_cycle(); req_valid = 4'b0101; #1;
        check("wrap_g0", 32'(req_grant), 32'b0001);
        next_cycle(); #1;
        check("wrap_g2", 32'(req_grant), 32'b0100);
        next_cycle(); req_valid = 4'b1001; #1;
        check("wrap_ptr3", 32'(req_grant), 32'b1000);

        // Freeze: issue A=3,B=5,tag=7 then stall three cycles
        next_cycle();
        req_busA[15:0] = 16'd3; req_busB[15:0] = 16'd5; req_tag_ROB[4:0] = 5'd7;
        req_valid = 4'b0001; #1;
        check("frz_issue", 32'(req_grant), 32'b0001);
        for (int k = 0; k < 3; k++) begin
            next_cycle(); freeze_back = 1'b1; req_valid = 4'b1111; #1;
            check($sformatf("frz_grant%0d", k), 32'(req_grant), 32'h0);
            check($sformatf("frz_valid%0d", k), 32'(valid_mul), 32'h1);
            check($sformatf("frz_busA%0d", k), 32'(busA_mul), 32'd3);
            check($sformatf("frz_busB%0d", k), 32'(busB_mul), 32'd5);
            check($sformatf("frz_tag%0d", k), 32'(tag_ROB_mul), 32'd7);
            check($sformatf("frz_cnt%0d", k), 32'(inflight_cnt), 32'd3);
        end
        next_cycle(); freeze_back = 1'b0; #1;
        check("frz_resume_g1", 32'(req_grant), 32'b0010);
        check("frz_resume_busA", 32'(busA_mul), 32'd3);
        next_cycle(); #1;
        check("frz_resume_g2", 32'(req_grant), 32'b0100);
        check("frz_resume_busA1", 32'(busA_mul), 32'h0A01);
        check("frz_resume_cnt", 32'(inflight_cnt), 32'd3);

        // Flush with freeze_back also high
        next_cycle(); flush = 1'b1; freeze_back = 1'b1; #1;
        check("fl_grant", 32'(req_grant), 32'h0);
        check("fl_cnt_before", 32'(inflight_cnt), 32'd3);
        next_cycle(); flush = 1'b0; freeze_back = 1'b0; req_valid = 4'b1001; #1;
        check("fl_valid", 32'(valid_mul), 32'h0);
        check("fl_cnt", 32'(inflight_cnt), 32'd0);
        check("fl_busy", 32'(mul_busy), 32'h0);
        check("fl_busA", 32'(busA_mul), 32'h0);
        check("fl_ptr_hold", 32'(req_grant), 32'b1000);

        // Build occupancy 3, then drain
        next_cycle(); req_valid = 4'b1111; #1;
        check("dr_g0", 32'(req_grant), 32'b0001);
        check("dr_cnt_a", 32'(inflight_cnt), 32'd1);
        next_cycle(); #1;
        check("dr_g1", 32'(req_grant), 32'b0010);
        next_cycle(); drain_req = 1'b1; req_valid = 4'b0000; #1;
        check("dr_cnt3", 32'(inflight_cnt), 32'd3);
        check("dr_grant_a", 32'(req_grant), 32'h0);
        next_cycle(); req_valid = 4'b1111; #1;
        check("dr_grant_b", 32'(req_grant), 32'h0);
        check("dr_cnt2", 32'(inflight_cnt), 32'd2);
        check("dr_not_yet", 32'(drained), 32'h0);
        next_cycle(); #1;
        check("dr_cnt1", 32'(inflight_cnt), 32'd1);
        next_cycle(); #1;
        check("dr_cnt0", 32'(inflight_cnt), 32'd0);
        check("dr_drained_late", 32'(drained), 32'h0);
        next_cycle(); #1;
        check("dr_drained", 32'(drained), 32'h1);
        check("dr_grant_c", 32'(req_grant), 32'h0);
        check("dr_busy", 32'(mul_busy), 32'h0);
        next_cycle(); drain_req = 1'b0; #1;
        check("dr_exit_grant", 32'(req_grant), 32'h0);
        check("dr_exit_drained", 32'(drained), 32'h1);
        next_cycle(); #1;
        check("run_drained", 32'(drained), 32'h0);
        check("run_grant", 32'(req_grant), 32'b0100);

        // Reset mid-run with valid_mul and s1 set, rr_ptr non-zero
        next_cycle(); req_valid = 4'b0001; #1;
        check("pre_rst_g", 32'(req_grant), 32'b0001);
        next_cycle(); req_valid = 4'b0011; #1;
        check("pre_rst_cnt", 32'(inflight_cnt), 32'd2);
        check("pre_rst_grant", 32'(req_grant), 32'b0010);
        rst = 1'b0; #1;
        check("mid_rst_valid", 32'(valid_mul), 32'h0);
        check("mid_rst_cnt", 32'(inflight_cnt), 32'h0);
        check("mid_rst_busy", 32'(mul_busy), 32'h0);
        check("mid_rst_busA", 32'(busA_mul), 32'h0);
        check("mid_rst_grant", 32'(req_grant), 32'h0);
        @(negedge clk); rst = 1'b1; #1;
        check("post_rst_ptr0", 32'(req_grant), 32'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
